dis_act_gen: RTL and testbench

DIS_ACT_GEN -- requirements
Module: dis_act_gen

---
 rtl/dis_act_pkg.sv | 40 ++++
 rtl/act_pack_buf.sv | 86 ++++++++
 rtl/dis_act_gen.sv | 161 ++++++++++++++++
 tb/tb_dis_act_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dis_act_pkg.sv
// -----------------------------------------------------------------------------
// dis_act_pkg
//   Shared definitions for the activation distributor (dis_act_gen) and its
//   packing buffer (act_pack_buf):
//     - default parameter values
//     - FSM state encoding
//     - popcount and ceiling-divide helpers
// -----------------------------------------------------------------------------
package dis_act_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BLOCK_DEPTH = 32;
  localparam int DEF_RD_WORDS    = 4;
  localparam int DEF_ADDR_WIDTH  = 10;

  // Widest flag vector the popcount helper accepts; callers zero-extend.
  localparam int MAX_DEPTH = 256;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECKDATA = 3'd1;
  localparam logic [2:0] S_FLAGWAIT  = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_WAITGET   = 3'd5;

  function automatic int unsigned f_popcount(input logic [MAX_DEPTH-1:0] i_vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i_vec[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic int unsigned f_ceil_div(input int unsigned i_num,
                                             input int unsigned i_den);
    return (i_num + i_den - 1) / i_den;
  endfunction

endpackage

// File: rtl/act_pack_buf.sv
// -----------------------------------------------------------------------------
// act_pack_buf
//   Assembles one block of activations from successive GBF read words.
//   Each write delivers RD_WORDS activations; a write pointer (in activation
//   units) tracks how many activations of the block have arrived so far.
//   Activations beyond the block count are discarded.
//   Build option DIS_ACT_GEN_SCATTER_EN: activation i lands at the slot of the
//   i-th set flag instead of slot i.
//
// Ports
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear buffer and write pointer (block start / restart)
//   i_wr       : i_word holds valid read data this cycle
//   i_cnt      : number of activations in the block
//   i_flags    : block flags (scatter build only)
//   i_word     : RD_WORDS activations, word 0 in LSBs
//   o_act      : assembled block, slot 0 in LSBs
// -----------------------------------------------------------------------------
module act_pack_buf
  import dis_act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_DEPTH = DEF_BLOCK_DEPTH,
  parameter int RD_WORDS    = DEF_RD_WORDS,
  parameter int CNT_W       = $clog2(BLOCK_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_clr,
  input  logic                              i_wr,
  input  logic [CNT_W-1:0]                  i_cnt,
`ifdef DIS_ACT_GEN_SCATTER_EN
  input  logic [BLOCK_DEPTH-1:0]            i_flags,
`endif
  input  logic [DATA_WIDTH*RD_WORDS-1:0]    i_word,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] o_act
);

  logic [CNT_W-1:0]                  r_wr_ptr;
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] r_act;
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] w_act_nxt;

  // For each output slot, find which activation index belongs there and
  // whether that index is part of the word currently arriving.
  always_comb begin
    int   k;
    int   rank;
    logic hit;
    w_act_nxt = r_act;
    k         = 0;
    rank      = 0;
    hit       = 1'b0;
    for (int s = 0; s < BLOCK_DEPTH; s++) begin
`ifdef DIS_ACT_GEN_SCATTER_EN
      rank = 0;
      for (int t = 0; t < s; t++) begin
        if (i_flags[t]) rank++;
      end
      k   = rank - int'(r_wr_ptr);
      hit = i_flags[s] && (rank < int'(i_cnt)) && (k >= 0) && (k < RD_WORDS);
`else
      k   = s - int'(r_wr_ptr);
      hit = (s < int'(i_cnt)) && (k >= 0) && (k < RD_WORDS);
`endif
      if (i_wr && hit) begin
        w_act_nxt[s*DATA_WIDTH +: DATA_WIDTH] = i_word[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act    <= '0;
      r_wr_ptr <= '0;
    end else if (i_clr) begin
      r_act    <= '0;
      r_wr_ptr <= '0;
    end else if (i_wr) begin
      r_act    <= w_act_nxt;
      r_wr_ptr <= r_wr_ptr + CNT_W'(RD_WORDS);
    end
  end

  assign o_act = r_act;

endmodule

// File: rtl/dis_act_gen.sv
// -----------------------------------------------------------------------------
// dis_act_gen
//   Activation distributor. On request, reads one flag word from the flag GBF,
//   then reads ceil(N/RD_WORDS) activation words (N = set flags) from the
//   activation GBF, assembles the block and presents it until the consumer
//   takes it. Both GBFs return data one cycle after the read enable.
//   Build option DIS_ACT_GEN_SCATTER_EN: activations are scattered to their
//   flagged slots instead of packed densely from slot 0.
//
// State | meaning
//   IDLE      | no block in progress
//   CHECKDATA | wait for both GBFs valid, issue flag read
//   FLAGWAIT  | flag data returns; register flags and count N
//   FETCH     | issue activation reads, stall while GBFACT_Val low
//   DRAIN     | capture data of the final activation read
//   WAITGET   | block ready, hold until CTRLACT_GetAct
//
// Ports
//   clk, rst_n                     : clock, async active-low reset
//   CTRLACT_PlsFetch/Restart/GetAct: controller request / sync restart / accept
//   DISACT_RdyAct/FlgAct/Act       : block ready, block flags, block data
//   GBFFLGACT_*                    : flag GBF read port
//   GBFACT_*                       : activation GBF read port
// -----------------------------------------------------------------------------
module dis_act_gen
  import dis_act_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_DEPTH = DEF_BLOCK_DEPTH,
  parameter int RD_WORDS    = DEF_RD_WORDS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              CTRLACT_PlsFetch,
  input  logic                              CTRLACT_Restart,
  input  logic                              CTRLACT_GetAct,
  output logic                              DISACT_RdyAct,
  output logic [BLOCK_DEPTH-1:0]            DISACT_FlgAct,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] DISACT_Act,
  input  logic                              GBFFLGACT_Val,
  output logic                              GBFFLGACT_EnRd,
  output logic [ADDR_WIDTH-1:0]             GBFFLGACT_AddrRd,
  input  logic [BLOCK_DEPTH-1:0]            GBFFLGACT_DatRd,
  input  logic                              GBFACT_Val,
  output logic                              GBFACT_EnRd,
  output logic [ADDR_WIDTH-1:0]             GBFACT_AddrRd,
  input  logic [DATA_WIDTH*RD_WORDS-1:0]    GBFACT_DatRd
);

  localparam int CNT_W = $clog2(BLOCK_DEPTH) + 1;

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic                   r_pend;
  logic [ADDR_WIDTH-1:0]  r_addr_flg;
  logic [ADDR_WIDTH-1:0]  r_addr_act;
  logic [BLOCK_DEPTH-1:0] r_flg;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_rd_left;
  logic [CNT_W-1:0]       w_flg_cnt;
  logic                   r_act_vld;
  logic                   w_flg_en;
  logic                   w_act_en;
  logic                   w_buf_clr;

  assign w_flg_cnt = CNT_W'(f_popcount(MAX_DEPTH'(GBFFLGACT_DatRd)));

  assign w_flg_en = !CTRLACT_Restart && (r_state == S_CHECKDATA) &&
                    GBFFLGACT_Val && GBFACT_Val;
  assign w_act_en = !CTRLACT_Restart && (r_state == S_FETCH) && GBFACT_Val;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (CTRLACT_PlsFetch || r_pend) w_state_nxt = S_CHECKDATA;
      S_CHECKDATA: if (w_flg_en) w_state_nxt = S_FLAGWAIT;
      S_FLAGWAIT:  w_state_nxt = (w_flg_cnt == '0) ? S_WAITGET : S_FETCH;
      S_FETCH:     if (w_act_en && (r_rd_left == CNT_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN:     w_state_nxt = S_WAITGET;
      S_WAITGET: begin
        if (CTRLACT_GetAct) begin
          w_state_nxt = (r_pend || CTRLACT_PlsFetch) ? S_CHECKDATA : S_IDLE;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_addr_flg <= '0;
      r_addr_act <= '0;
      r_flg      <= '0;
      r_cnt      <= '0;
      r_rd_left  <= '0;
      r_act_vld  <= 1'b0;
    end else if (CTRLACT_Restart) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_addr_flg <= '0;
      r_addr_act <= '0;
      r_rd_left  <= '0;
      r_act_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_act_vld <= w_act_en;
      if (w_flg_en) r_addr_flg <= r_addr_flg + 1'b1;
      if (w_act_en) begin
        r_addr_act <= r_addr_act + 1'b1;
        r_rd_left  <= r_rd_left - 1'b1;
      end
      if (r_state == S_FLAGWAIT) begin
        r_flg     <= GBFFLGACT_DatRd;
        r_cnt     <= w_flg_cnt;
        r_rd_left <= CNT_W'(f_ceil_div(32'(w_flg_cnt), 32'(RD_WORDS)));
      end
      // One-deep request memory: only a taken block clears it, and requests
      // seen in IDLE are served directly rather than remembered.
      if (r_state == S_IDLE) begin
        r_pend <= 1'b0;
      end else if ((r_state == S_WAITGET) && CTRLACT_GetAct) begin
        r_pend <= 1'b0;
      end else if (CTRLACT_PlsFetch) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Buffer is cleared as each new block's flags arrive, so a zero-flag block
  // presents all-zero data and leftovers from a restarted block never leak.
  assign w_buf_clr = CTRLACT_Restart || (r_state == S_FLAGWAIT);

  act_pack_buf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BLOCK_DEPTH (BLOCK_DEPTH),
    .RD_WORDS    (RD_WORDS),
    .CNT_W       (CNT_W)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_buf_clr),
    .i_wr    (r_act_vld),
    .i_cnt   (r_cnt),
`ifdef DIS_ACT_GEN_SCATTER_EN
    .i_flags (r_flg),
`endif
    .i_word  (GBFACT_DatRd),
    .o_act   (DISACT_Act)
  );

  assign DISACT_RdyAct    = (r_state == S_WAITGET);
  assign DISACT_FlgAct    = r_flg;
  assign GBFFLGACT_EnRd   = w_flg_en;
  assign GBFFLGACT_AddrRd = r_addr_flg;
  assign GBFACT_EnRd      = w_act_en;
  assign GBFACT_AddrRd    = r_addr_act;

endmodule

// File: tb/tb_dis_act_gen.sv
module tb_dis_act_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         CTRLACT_PlsFetch, CTRLACT_Restart, CTRLACT_GetAct;
  logic         DISACT_RdyAct;
  logic [31:0]  DISACT_FlgAct;
  logic [255:0] DISACT_Act;
  logic         GBFFLGACT_Val, GBFFLGACT_EnRd;
  logic [9:0]   GBFFLGACT_AddrRd;
  logic [31:0]  GBFFLGACT_DatRd;
  logic         GBFACT_Val, GBFACT_EnRd;
  logic [9:0]   GBFACT_AddrRd;
  logic [31:0]  GBFACT_DatRd;

  logic [31:0] flag_mem [1024];
  logic [31:0] act_mem  [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dis_act_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .CTRLACT_PlsFetch (CTRLACT_PlsFetch),
    .CTRLACT_Restart  (CTRLACT_Restart),
    .CTRLACT_GetAct   (CTRLACT_GetAct),
    .DISACT_RdyAct    (DISACT_RdyAct),
    .DISACT_FlgAct    (DISACT_FlgAct),
    .DISACT_Act       (DISACT_Act),
    .GBFFLGACT_Val    (GBFFLGACT_Val),
    .GBFFLGACT_EnRd   (GBFFLGACT_EnRd),
    .GBFFLGACT_AddrRd (GBFFLGACT_AddrRd),
    .GBFFLGACT_DatRd  (GBFFLGACT_DatRd),
    .GBFACT_Val       (GBFACT_Val),
    .GBFACT_EnRd      (GBFACT_EnRd),
    .GBFACT_AddrRd    (GBFACT_AddrRd),
    .GBFACT_DatRd     (GBFACT_DatRd)
  );

  // GBF models: one-cycle read latency
  always @(posedge clk) begin
    if (GBFFLGACT_EnRd) GBFFLGACT_DatRd <= flag_mem[GBFFLGACT_AddrRd];
    if (GBFACT_EnRd)    GBFACT_DatRd    <= act_mem[GBFACT_AddrRd];
  end

  typedef struct {
    string        name;
    logic [31:0]  flags;
    logic [255:0] words;
    int           stall_lo;
    int           stall_hi;
    int           exp_rdy;
    int           exp_nrd;
    int           exp_first;
    logic [255:0] exp_act;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [31:0] f, logic [255:0] w, int lo, int hi,
                              int rdy, int nrd, int first, logic [255:0] act);
    vec_t v;
    v.name = nm; v.flags = f; v.words = w; v.stall_lo = lo; v.stall_hi = hi;
    v.exp_rdy = rdy; v.exp_nrd = nrd; v.exp_first = first; v.exp_act = act;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    step();
    CTRLACT_Restart = 1'b1;
    step();
    CTRLACT_Restart = 1'b0;
  endtask

  task automatic get_act();
    step();
    CTRLACT_GetAct = 1'b1;
    step();
    CTRLACT_GetAct = 1'b0;
  endtask

  // Pulses PlsFetch in cycle 0 and returns at the negedge of the ready cycle.
  task automatic run_block(input int lo, input int hi, output int rdy_cyc,
                           output int nrd, output int first_rd, output int flg_cyc);
    int cyc;
    rdy_cyc = -1; nrd = 0; first_rd = -1; flg_cyc = -1;
    step();
    CTRLACT_PlsFetch = 1'b1;
    GBFACT_Val = 1'b1;
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (GBFFLGACT_EnRd && flg_cyc < 0) flg_cyc = cyc;
      if (GBFACT_EnRd) begin
        nrd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (DISACT_RdyAct) begin
        rdy_cyc = cyc;
        break;
      end
      step();
      CTRLACT_PlsFetch = 1'b0;
      cyc++;
      GBFACT_Val = !(cyc >= lo && cyc <= hi);
    end
    CTRLACT_PlsFetch = 1'b0;
    GBFACT_Val = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy, nrd, first, flgc, bad, cnt, w;
    logic [255:0] exp_two;

    rst_n = 1'b0;
    CTRLACT_PlsFetch = 1'b0; CTRLACT_Restart = 1'b0; CTRLACT_GetAct = 1'b0;
    GBFFLGACT_Val = 1'b1; GBFACT_Val = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      flag_mem[i] = '0;
      act_mem[i]  = '0;
    end

`ifdef DIS_ACT_GEN_SCATTER_EN
    exp_two = {8'hBB, 240'h0, 8'hAA};
`else
    exp_two = 256'hBBAA;
`endif

    vecs.push_back(mk("ff8", 32'h000000FF, 256'h08070605_04030201, -1, -1, 6, 2, 3,
                      256'h0807060504030201));
    vecs.push_back(mk("zero", 32'h00000000, 256'hDEADBEEF, -1, -1, 3, 0, -1, 256'h0));
    vecs.push_back(mk("full", 32'hFFFFFFFF,
                      256'h201F1E1D_1C1B1A19_18171615_14131211_100F0E0D_0C0B0A09_08070605_04030201,
                      -1, -1, 12, 8, 3,
                      256'h201F1E1D_1C1B1A19_18171615_14131211_100F0E0D_0C0B0A09_08070605_04030201));
    vecs.push_back(mk("n3", 32'h00000007, 256'hDDCCBBAA, -1, -1, 5, 1, 3, 256'hCCBBAA));
    vecs.push_back(mk("stall", 32'h000000FF, 256'h08070605_04030201, 3, 5, 9, 2, 6,
                      256'h0807060504030201));
    vecs.push_back(mk("n17", 32'h0001FFFF,
                      256'h14131211_100F0E0D_0C0B0A09_08070605_04030201, -1, -1, 9, 5, 3,
                      256'h11_100F0E0D_0C0B0A09_08070605_04030201));
    vecs.push_back(mk("two", 32'h80000001, 256'h0000BBAA, -1, -1, 5, 1, 3, exp_two));

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  256'(DISACT_RdyAct), 256'h0);
    chk("rst_flg",  256'(DISACT_FlgAct), 256'h0);
    chk("rst_act",  DISACT_Act, 256'h0);
    chk("rst_en",   256'({GBFFLGACT_EnRd, GBFACT_EnRd}), 256'h0);
    chk("rst_addr", 256'({GBFFLGACT_AddrRd, GBFACT_AddrRd}), 256'h0);
    step();
    rst_n = 1'b1;

    // table-driven blocks
    for (int vi = 0; vi < vecs.size(); vi++) begin
      do_restart();
      flag_mem[0] = vecs[vi].flags;
      for (int k = 0; k < 8; k++) act_mem[k] = vecs[vi].words[k*32 +: 32];
      run_block(vecs[vi].stall_lo, vecs[vi].stall_hi, rdy, nrd, first, flgc);
      chk_i($sformatf("%s_rdy_cyc", vecs[vi].name), rdy, vecs[vi].exp_rdy);
      chk_i($sformatf("%s_flg_cyc", vecs[vi].name), flgc, 1);
      chk_i($sformatf("%s_nrd", vecs[vi].name), nrd, vecs[vi].exp_nrd);
      chk_i($sformatf("%s_first_rd", vecs[vi].name), first, vecs[vi].exp_first);
      chk($sformatf("%s_act", vecs[vi].name), DISACT_Act, vecs[vi].exp_act);
      chk($sformatf("%s_flgact", vecs[vi].name), 256'(DISACT_FlgAct), 256'(vecs[vi].flags));
      chk_i($sformatf("%s_act_addr", vecs[vi].name), int'(GBFACT_AddrRd), vecs[vi].exp_nrd);
      chk_i($sformatf("%s_flg_addr", vecs[vi].name), int'(GBFFLGACT_AddrRd), 1);
      get_act();
      @(negedge clk);
      chk_i($sformatf("%s_rdy_drop", vecs[vi].name), int'(DISACT_RdyAct), 0);
    end

    // pending request during FETCH, dropped second pulse, ignored early GetAct
    do_restart();
    flag_mem[0] = 32'h000000FF; flag_mem[1] = 32'h00000007;
    act_mem[0] = 32'h04030201; act_mem[1] = 32'h08070605; act_mem[2] = 32'h00332211;
    step(); CTRLACT_PlsFetch = 1'b1;                         // c0
    step(); CTRLACT_PlsFetch = 1'b0;                         // c1
    step();                                                  // c2
    step(); CTRLACT_PlsFetch = 1'b1; CTRLACT_GetAct = 1'b1;  // c3
    step(); CTRLACT_PlsFetch = 1'b0; CTRLACT_GetAct = 1'b0;  // c4
    step(); CTRLACT_PlsFetch = 1'b1;                         // c5
    step(); CTRLACT_PlsFetch = 1'b0;                         // c6
    @(negedge clk);
    chk_i("pend_rdy_c6", int'(DISACT_RdyAct), 1);
    chk("pend_act1", DISACT_Act, 256'h0807060504030201);
    step();                                                  // c7
    @(negedge clk);
    chk_i("pend_rdy_hold", int'(DISACT_RdyAct), 1);
    chk("pend_act_hold", DISACT_Act, 256'h0807060504030201);
    step(); CTRLACT_GetAct = 1'b1;                           // c8
    step(); CTRLACT_GetAct = 1'b0;                           // c9
    @(negedge clk);
    chk_i("pend_next_flgrd", int'(GBFFLGACT_EnRd), 1);
    chk_i("pend_rdy_low", int'(DISACT_RdyAct), 0);
    w = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      @(negedge clk);
      if (DISACT_RdyAct) begin
        w = i;
        break;
      end
    end
    chk_i("pend_blk2_lat", w, 4);
    chk("pend_act2", DISACT_Act, 256'h332211);
    get_act();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (GBFFLGACT_EnRd || DISACT_RdyAct) cnt++;
    end
    chk_i("pend_dropped", cnt, 0);

    // restart during FETCH
    do_restart();
    flag_mem[0] = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) act_mem[k] = 32'h11111111 * (k + 1);
    step(); CTRLACT_PlsFetch = 1'b1;   // c0
    step(); CTRLACT_PlsFetch = 1'b0;   // c1
    repeat (3) step();                 // c2..c4
    step(); CTRLACT_Restart = 1'b1;    // c5
    @(negedge clk);
    chk_i("rstrt_enrd_low", int'(GBFACT_EnRd), 0);
    step(); CTRLACT_Restart = 1'b0;    // c6
    @(negedge clk);
    chk_i("rstrt_act_addr", int'(GBFACT_AddrRd), 0);
    chk_i("rstrt_flg_addr", int'(GBFFLGACT_AddrRd), 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      @(negedge clk);
      if (DISACT_RdyAct || GBFACT_EnRd || GBFFLGACT_EnRd) cnt++;
    end
    chk_i("rstrt_quiet", cnt, 0);

    // async reset during FETCH
    do_restart();
    step(); CTRLACT_PlsFetch = 1'b1;   // c0
    step(); CTRLACT_PlsFetch = 1'b0;   // c1
    repeat (3) step();                 // c2..c4
    step(); rst_n = 1'b0;              // c5
    @(negedge clk);
    chk("mrst_act", DISACT_Act, 256'h0);
    chk("mrst_flg", 256'(DISACT_FlgAct), 256'h0);
    chk_i("mrst_act_addr", int'(GBFACT_AddrRd), 0);
    chk_i("mrst_en", int'({GBFFLGACT_EnRd, GBFACT_EnRd, DISACT_RdyAct}), 0);
    step(); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (DISACT_RdyAct || GBFACT_EnRd) cnt++;
    end
    chk_i("mrst_quiet", cnt, 0);

    // address wrap: 1023 one-read blocks, then one more reading address 1023
    do_restart();
    for (int i = 0; i < 1024; i++) begin
      flag_mem[i] = 32'h0000000F;
      act_mem[i]  = 32'h04030201;
    end
    act_mem[1023] = 32'hA3A2A1A0;
    bad = 0;
    for (int b = 0; b < 1023; b++) begin
      run_block(-1, -1, rdy, nrd, first, flgc);
      if (rdy != 5 || nrd != 1) bad++;
      get_act();
    end
    chk_i("wrap_loop_bad", bad, 0);
    @(negedge clk);
    chk_i("wrap_act_addr_1023", int'(GBFACT_AddrRd), 1023);
    chk_i("wrap_flg_addr_1023", int'(GBFFLGACT_AddrRd), 1023);
    run_block(-1, -1, rdy, nrd, first, flgc);
    chk_i("wrap_rdy", rdy, 5);
    chk("wrap_act", DISACT_Act, 256'hA3A2A1A0);
    chk_i("wrap_act_addr_0", int'(GBFACT_AddrRd), 0);
    chk_i("wrap_flg_addr_0", int'(GBFFLGACT_AddrRd), 0);
    get_act();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
